// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between N_REQ packet sources, the arbiter and one UART transmitter.
// The slave view is the arbiter; the master view drives requesters and the UART side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [8*N_REQ-1:0]       req_tdata;
    logic [N_REQ-1:0]         req_tvalid;
    logic [N_REQ-1:0]         req_tlast;
    logic [N_REQ-1:0]         req_tready;
    logic [7:0]               tx_tdata;
    logic                     tx_tvalid;
    logic                     tx_tready;
    logic [$clog2(N_REQ)-1:0] grant;
    logic                     busy;
    logic                     timeout_err;

    modport slave (
        input  req_tdata, req_tvalid, req_tlast, tx_tready,
        output req_tready, tx_tdata, tx_tvalid, grant, busy, timeout_err
    );

    modport master (
        output req_tdata, req_tvalid, req_tlast, tx_tready,
        input  req_tready, tx_tdata, tx_tvalid, grant, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter feeding one UART transmitter; a granted requester keeps
// the UART until its tlast beat, or until it stalls for TIMEOUT idle cycles.
//
// state | meaning
// IDLE  | no owner; pick next requester after `last` in round-robin order
// PASS  | owner's stream passed straight through to the UART until tlast or abort
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             nrst,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT);

    typedef enum logic {IDLE, PASS} state_t;

    state_t        state;
    logic [GW-1:0] grant_q;
    logic [GW-1:0] last_q;
    logic [CW-1:0] idle_cnt;
    logic          busy_q;
    logic          timeout_q;

    logic [GW-1:0] pick;
    logic [GW-1:0] idx;
    logic          pick_found;
    logic          own_valid;
    logic          own_last;
    logic [7:0]    data_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = bus.req_tdata[8*i +: 8];
        end
    end

    // Scan from farthest to nearest so the nearest valid requester after last_q wins.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = GW'((int'(last_q) + k) % N_REQ);
            if (bus.req_tvalid[idx]) begin
                pick_found = 1'b1;
                pick       = idx;
            end
        end
    end

    assign own_valid = bus.req_tvalid[grant_q];
    assign own_last  = bus.req_tlast[grant_q];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            grant_q   <= '0;
            last_q    <= GW'(N_REQ - 1);
            idle_cnt  <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_q  <= pick;
                        last_q   <= pick;
                        idle_cnt <= '0;
                        busy_q   <= 1'b1;
                        state    <= PASS;
                    end
                end
                PASS: begin
                    // A presented byte (even if back-pressured) proves the owner is alive.
                    if (own_valid) begin
                        idle_cnt <= '0;
                        if (bus.tx_tready && own_last) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (idle_cnt >= CNT_TOP - 1'b1) begin
                        idle_cnt  <= CNT_TOP;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.tx_tvalid  = 1'b0;
        bus.tx_tdata   = 8'h00;
        bus.req_tready = '0;
        if (state == PASS) begin
            bus.tx_tvalid           = own_valid;
            bus.tx_tdata            = data_arr[grant_q];
            bus.req_tready[grant_q] = bus.tx_tready;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes each byte into per-requester
// expected queues, a negedge monitor runs a packet-level model and pops on every beat.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        int         g;
        logic [7:0] d;
    } beat_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [8:0] drv_q [N][$];
    logic [8:0] exp_q [N][$];
    beat_t      beat_log [$];
    int         to_cnt = 0;
    int         to_cyc = 0;
    bit         rand_gaps  = 1'b0;
    bit         rand_ready = 1'b0;
    bit         ready_val  = 1'b1;
    int         gap [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round robin: first valid index after `last`, wrapping.
    function automatic int rr(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l);
        drv_q[r].push_back({l, d});
        exp_q[r].push_back({l, d});
    endtask

    // Requester and UART-ready driver: acceptance sampled at negedge, new values after posedge.
    initial begin
        logic [8*N-1:0] td;
        logic [N-1:0]   tv;
        logic [N-1:0]   tl;
        bus.req_tdata  = '0;
        bus.req_tvalid = '0;
        bus.req_tlast  = '0;
        bus.tx_tready  = 1'b1;
        for (int i = 0; i < N; i++) gap[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (nrst && bus.req_tvalid[i] && bus.req_tready[i]) begin
                    void'(drv_q[i].pop_front());
                    gap[i] = (rand_gaps && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
                end
            end
            @(posedge clk);
            #1;
            td = '0;
            tv = '0;
            tl = '0;
            for (int i = 0; i < N; i++) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else if (drv_q[i].size() > 0) begin
                    tv[i]          = 1'b1;
                    td[8*i +: 8]   = drv_q[i][0][7:0];
                    tl[i]          = drv_q[i][0][8];
                end
            end
            bus.req_tdata  = td;
            bus.req_tvalid = tv;
            bus.req_tlast  = tl;
            bus.tx_tready  = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    // Monitor: packet-level model of ownership, idle timeout and round-robin order.
    initial begin
        int         m_last;
        int         m_g;
        int         m_idle;
        bit         m_pass;
        bit         m_to;
        logic [8:0] e;
        m_last = N - 1;
        m_g    = 0;
        m_idle = 0;
        m_pass = 1'b0;
        m_to   = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                chk("rst_busy", bus.busy, 0);
                chk("rst_tx_tvalid", bus.tx_tvalid, 0);
                chk("rst_grant", bus.grant, 0);
                chk("rst_timeout_err", bus.timeout_err, 0);
                chk("rst_req_tready", bus.req_tready, 0);
                m_last = N - 1;
                m_pass = 1'b0;
                m_to   = 1'b0;
                m_idle = 0;
            end else begin
                chk("busy", bus.busy, m_pass);
                chk("timeout_err", bus.timeout_err, m_to);
                if (bus.timeout_err) begin
                    to_cnt++;
                    to_cyc = cyc;
                end
                m_to = 1'b0;
                if (!m_pass) begin
                    chk("idle_tx_tvalid", bus.tx_tvalid, 0);
                    chk("idle_tx_tdata", bus.tx_tdata, 0);
                    chk("idle_req_tready", bus.req_tready, 0);
                    if (bus.req_tvalid != '0) begin
                        m_g    = rr(m_last, bus.req_tvalid);
                        m_last = m_g;
                        m_pass = 1'b1;
                        m_idle = 0;
                    end
                end else begin
                    chk("grant", bus.grant, m_g);
                    chk("tx_tvalid", bus.tx_tvalid, bus.req_tvalid[m_g]);
                    chk("req_tready", bus.req_tready, bus.tx_tready ? (1 << m_g) : 0);
                    if (bus.req_tvalid[m_g]) begin
                        m_idle = 0;
                        if (bus.tx_tready) begin
                            chk("sb_nonempty", exp_q[m_g].size() > 0, 1);
                            if (exp_q[m_g].size() > 0) begin
                                e = exp_q[m_g].pop_front();
                                chk("tx_tdata", bus.tx_tdata, e[7:0]);
                                beat_log.push_back('{cyc, int'(bus.grant), bus.tx_tdata});
                                if (e[8]) m_pass = 1'b0;
                            end
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin
                            m_pass = 1'b0;
                            m_to   = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_beats(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (beat_log.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        chk(name, beat_log.size() >= n, 1);
    endtask

    task automatic drain(input string name);
        int t;
        bit done;
        t    = 0;
        done = 1'b0;
        while (t < 4000) begin
            done = !bus.busy;
            for (int r = 0; r < N; r++) if (exp_q[r].size() != 0) done = 1'b0;
            if (done) break;
            @(posedge clk);
            t++;
        end
        chk(name, done, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 nrst = 1'b0;
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int b;
        int n;
        int t0;
        int t;
        int len;
        int total;
        nrst = 1'b1;
        #2 nrst = 1'b0;
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;
        @(posedge clk);

        // Two simultaneous 2-byte packets: requester 0 first, one bubble, then requester 2.
        b = beat_log.size();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        wait_beats(b + 4, 50, "t1_beats");
        chk("t1_d0", beat_log[b].d, 8'hA1);
        chk("t1_g0", beat_log[b].g, 0);
        chk("t1_d1", beat_log[b+1].d, 8'hA2);
        chk("t1_d2", beat_log[b+2].d, 8'hC1);
        chk("t1_g2", beat_log[b+2].g, 2);
        chk("t1_d3", beat_log[b+3].d, 8'hC2);
        chk("t1_back_to_back", beat_log[b+1].cyc - beat_log[b].cyc, 1);
        chk("t1_bubble", beat_log[b+2].cyc - beat_log[b+1].cyc, 2);
        drain("t1_drain");

        // Continuous single-byte packets from everyone: strict rotation, one packet per 2 cycles.
        do_reset();
        b = beat_log.size();
        for (int r = 0; r < N; r++)
            for (int p = 0; p < 2; p++) push(r, 8'(16 * r + p), 1'b1);
        wait_beats(b + 8, 100, "t2_beats");
        for (int k = 0; k < 8; k++) chk("t2_order", beat_log[b+k].g, k % N);
        for (int k = 1; k < 8; k++) chk("t2_spacing", beat_log[b+k].cyc - beat_log[b+k-1].cyc, 2);
        drain("t2_drain");

        // Back-pressure longer than TIMEOUT inside a packet must not abort it.
        do_reset();
        b  = beat_log.size();
        t0 = to_cnt;
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        wait_beats(b + 1, 20, "t3_first");
        ready_val = 1'b0;
        push(0, 8'h0F, 1'b1);
        repeat (10) @(posedge clk);
        ready_val = 1'b1;
        wait_beats(b + 4, 40, "t3_beats");
        chk("t3_d0", beat_log[b].d, 8'h31);
        chk("t3_d1", beat_log[b+1].d, 8'h32);
        chk("t3_d2", beat_log[b+2].d, 8'h33);
        chk("t3_g_owner", beat_log[b+2].g, 1);
        chk("t3_waiter_g", beat_log[b+3].g, 0);
        chk("t3_waiter_d", beat_log[b+3].d, 8'h0F);
        chk("t3_no_abort", to_cnt - t0, 0);
        drain("t3_drain");

        // Stalled owner: the pulse shows in the cycle after the TO-th idle cycle.
        do_reset();
        b  = beat_log.size();
        t0 = to_cnt;
        push(3, 8'h3A, 1'b0);
        wait_beats(b + 1, 20, "t4_beat");
        t = 0;
        while (to_cnt == t0 && t < 30) begin
            @(posedge clk);
            t++;
        end
        chk("t4_abort_seen", to_cnt - t0, 1);
        chk("t4_latency", to_cyc - beat_log[b].cyc, TO + 1);
        push(3, 8'h3B, 1'b1);
        push(0, 8'h0B, 1'b1);
        wait_beats(b + 3, 30, "t4_after");
        chk("t4_next_g", beat_log[b+1].g, 0);
        chk("t4_then_g", beat_log[b+2].g, 3);
        drain("t4_drain");

        // Reset in the middle of requester 2's packet; pending requester 0 wins afterwards.
        do_reset();
        b = beat_log.size();
        push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b0); push(2, 8'h24, 1'b1);
        wait_beats(b + 1, 20, "t5_first");
        push(0, 8'h01, 1'b1);
        @(posedge clk);
        chk("t5_mid_busy", bus.busy, 1);
        #3 nrst = 1'b0;
        #1;
        chk("t5_rst_tvalid", bus.tx_tvalid, 0);
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_ready", bus.req_tready, 0);
        n = beat_log.size();
        repeat (2) @(posedge clk);
        #3 nrst = 1'b1;
        wait_beats(n + 1, 20, "t5_after");
        chk("t5_first_g", beat_log[n].g, 0);
        chk("t5_first_d", beat_log[n].d, 8'h01);
        drain("t5_drain");

        // Random packets, random inter-byte gaps (shorter than TO) and random UART ready.
        do_reset();
        rand_gaps  = 1'b1;
        rand_ready = 1'b1;
        b     = beat_log.size();
        t0    = to_cnt;
        total = 0;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 6; p++) begin
                len = int'($urandom_range(1, 5));
                for (int k = 0; k < len; k++) push(r, 8'($urandom), k == len - 1);
                total += len;
            end
        end
        drain("rand_drain");
        chk("rand_beats", beat_log.size() - b, total);
        chk("rand_no_abort", to_cnt - t0, 0);
        rand_gaps  = 1'b0;
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
